// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: datapath width,
// the NOP encoding used to fill an empty output slot, the default reset
// PC, and the next-PC selection encoding used by pc_register.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK       = 32'h0000_0003;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INCREMENT,
        PC_REDIRECT
    } pc_sel_e;

    // Sequential successor of a fetch address; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register with next-PC selection. A redirect always
// wins over sequential advance; otherwise the PC holds.
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic            advance,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    pc_sel_e         sel;
    logic [XLEN-1:0] pc_next;

    // Choose the PC source, giving redirect priority over advance.
    always_comb begin
        sel = PC_HOLD;
        if (redirect) begin
            sel = PC_REDIRECT;
        end else if (advance) begin
            sel = PC_INCREMENT;
        end
    end

    // Form the next PC value from the selected source.
    always_comb begin
        pc_next = pc;
        case (sel)
            PC_REDIRECT:  pc_next = target;
            PC_INCREMENT: pc_next = next_seq_pc(pc);
            default:      pc_next = pc;
        endcase
    end

    // PC state, forced to the reset vector while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to a combinational instruction
// memory, registers the returned word with a valid/ready handshake, and
// raises a sticky fault when fetching past the end of memory.
// Optional macro FETCH_MISALIGN_TRAP_EN: a redirect to a non word-aligned
// target faults instead of being silently aligned down.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     MEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            fault_o
);

    // Highest byte address at which a full word can still be fetched.
    localparam logic [XLEN-1:0] LAST_FETCH = XLEN'(MEM_BYTES - 4);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_target;
    logic            misaligned;
    logic            slot_free;
    logic            in_range;
    logic            load;
    logic            target_legal;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc_i;
    assign misaligned      = (redirect_pc_i & ALIGN_MASK) != '0;
`else
    assign redirect_target = redirect_pc_i & ~ALIGN_MASK;
    assign misaligned      = 1'b0;
`endif

    assign imem_addr    = pc;
    assign slot_free    = !valid_o || ready_i;
    assign in_range     = pc <= LAST_FETCH;
    assign load         = slot_free && !redirect_i && !fault_o && in_range;
    assign target_legal = !misaligned && (redirect_target <= LAST_FETCH);

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk      (clk),
        .rst_n    (rst_n),
        .redirect (redirect_i),
        .advance  (load),
        .target   (redirect_target),
        .pc       (pc)
    );

    // Output slot: flush on redirect, fill on load, empty once accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_o  <= NOP_INSTR;
            pc_o    <= '0;
            valid_o <= 1'b0;
        end else if (redirect_i) begin
            valid_o <= 1'b0;
        end else if (load) begin
            inst_o  <= imem_instr;
            pc_o    <= pc;
            valid_o <= 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // Sticky fault: set by an out-of-range fetch or a trapped misaligned
    // redirect, cleared only by a redirect to a legal target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_o <= 1'b0;
        end else if (redirect_i) begin
            fault_o <= fault_o ? !target_legal : misaligned;
        end else if (slot_free && !fault_o && !in_range) begin
            fault_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed vector table, hand-written
// bound/reset sequences, and randomized traffic against a reference model.
// Honors FETCH_MISALIGN_TRAP_EN in the same way as the design.
module tb_instruction_fetch;

    localparam int unsigned MEM_A = 1024;
    localparam int unsigned MEM_B = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;

    logic [31:0] imemAddrA, imemInstrA, targetA, instA, pcOutA;
    logic        redirectA, validA, readyA, faultA;

    logic [31:0] imemAddrB, imemInstrB, targetB, instB, pcOutB;
    logic        redirectB, validB, readyB, faultB;

    int checks;
    int errors;

    // Reference model state for the randomized phase.
    logic [31:0] mNext, mPc, mInst;
    logic        mValid, mFault;

    typedef struct {
        logic        redirect;
        logic [31:0] target;
        logic        ready;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expAddr;
        logic        expFault;
    } vec_t;

    vec_t vecs[$];

    // Instruction memory contents as a pure function of the byte address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imemInstrA = memWord(imemAddrA);
    assign imemInstrB = memWord(imemAddrB);

    instruction_fetch #(.RESET_PC(32'h0), .MEM_BYTES(MEM_A)) dutA (
        .clk(clk), .rst_n(rst_n), .imem_addr(imemAddrA), .imem_instr(imemInstrA),
        .redirect_i(redirectA), .redirect_pc_i(targetA), .inst_o(instA),
        .pc_o(pcOutA), .valid_o(validA), .ready_i(readyA), .fault_o(faultA)
    );

    instruction_fetch #(.RESET_PC(32'h0), .MEM_BYTES(MEM_B)) dutB (
        .clk(clk), .rst_n(rst_n), .imem_addr(imemAddrB), .imem_instr(imemInstrB),
        .redirect_i(redirectB), .redirect_pc_i(targetB), .inst_o(instB),
        .pc_o(pcOutB), .valid_o(validB), .ready_i(readyB), .fault_o(faultB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Drive dut A inputs, then sample one step after the next rising edge.
    task automatic applyStimulus(input logic redirect, input logic [31:0] target,
                                 input logic ready);
        redirectA = redirect;
        targetA   = target;
        readyA    = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        redirectA = 1'b0; targetA = '0; readyA = 1'b1;
        redirectB = 1'b0; targetB = '0; readyB = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic addVec(input logic rd, input logic [31:0] tg, input logic rdy,
                          input logic ev, input logic [31:0] ep, input logic [31:0] ea,
                          input logic ef);
        vec_t v;
        v.redirect = rd; v.target = tg; v.ready = rdy;
        v.expValid = ev; v.expPc = ep; v.expAddr = ea; v.expFault = ef;
        vecs.push_back(v);
    endtask

    // One clock of the fetch behaviour, stated directly from its rules.
    task automatic modelStep(input logic redirect, input logic [31:0] target,
                             input logic ready);
        logic [31:0] tgt;
        logic        mis;
        logic        legal;
        if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt = target;
            mis = (target % 4) != 0;
`else
            tgt = target - (target % 4);
            mis = 1'b0;
`endif
            legal  = !mis && (tgt <= MEM_A - 4);
            mFault = mFault ? !legal : mis;
            mValid = 1'b0;
            mNext  = tgt;
        end else if (!mValid || ready) begin
            if (mFault) begin
                mValid = 1'b0;
            end else if (mNext > MEM_A - 4) begin
                mFault = 1'b1;
                mValid = 1'b0;
            end else begin
                mPc    = mNext;
                mInst  = memWord(mNext);
                mValid = 1'b1;
                mNext  = mNext + 4;
            end
        end
    endtask

    initial begin
        logic        saw16;
        logic        rd;
        logic        rdy;
        logic [31:0] tg;
        checks = 0;
        errors = 0;

        // Directed vectors on dut A after reset release.
        addVec(0, 32'h0,  1, 1, 32'h00, 32'h04, 0);
        addVec(0, 32'h0,  1, 1, 32'h04, 32'h08, 0);
        addVec(0, 32'h0,  1, 1, 32'h08, 32'h0C, 0);
        addVec(0, 32'h0,  0, 1, 32'h08, 32'h0C, 0);
        addVec(0, 32'h0,  0, 1, 32'h08, 32'h0C, 0);
        addVec(0, 32'h0,  0, 1, 32'h08, 32'h0C, 0);
        addVec(0, 32'h0,  1, 1, 32'h0C, 32'h10, 0);
        addVec(0, 32'h0,  0, 1, 32'h0C, 32'h10, 0);
        addVec(1, 32'h40, 0, 0, 32'h00, 32'h40, 0);
        addVec(0, 32'h0,  0, 1, 32'h40, 32'h44, 0);
        addVec(0, 32'h0,  1, 1, 32'h44, 32'h48, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        addVec(1, 32'h22, 1, 0, 32'h00, 32'h22, 1);
        addVec(0, 32'h0,  1, 0, 32'h00, 32'h22, 1);
`else
        addVec(1, 32'h22, 1, 0, 32'h00, 32'h20, 0);
        addVec(0, 32'h0,  1, 1, 32'h20, 32'h24, 0);
`endif
        addVec(1, 32'h80, 1, 0, 32'h00, 32'h80, 0);
        addVec(0, 32'h0,  1, 1, 32'h80, 32'h84, 0);

        // Reset state while rst_n is held low.
        rst_n     = 1'b0;
        redirectA = 1'b0; targetA = '0; readyA = 1'b1;
        redirectB = 1'b0; targetB = '0; readyB = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", {31'b0, validA}, 32'h0);
        checkOutput("reset_inst", instA, NOP);
        checkOutput("reset_pc_o", pcOutA, 32'h0);
        checkOutput("reset_addr", imemAddrA, 32'h0);
        checkOutput("reset_fault", {31'b0, faultA}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].redirect, vecs[i].target, vecs[i].ready);
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, validA}, {31'b0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d_addr", i), imemAddrA, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_fault", i), {31'b0, faultA}, {31'b0, vecs[i].expFault});
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_pc_o", i), pcOutA, vecs[i].expPc);
                checkOutput($sformatf("vec%0d_inst", i), instA, memWord(vecs[i].expPc));
            end
        end

        // Memory bound on dut B: four words, then a sticky fault.
        doReset();
        saw16 = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            if (validB && pcOutB == 32'h10) saw16 = 1'b1;
            if (e < 4) begin
                checkOutput($sformatf("bound%0d_valid", e), {31'b0, validB}, 32'h1);
                checkOutput($sformatf("bound%0d_pc_o", e), pcOutB, 32'(4 * e));
                checkOutput($sformatf("bound%0d_fault", e), {31'b0, faultB}, 32'h0);
            end else begin
                checkOutput($sformatf("bound%0d_valid", e), {31'b0, validB}, 32'h0);
                checkOutput($sformatf("bound%0d_fault", e), {31'b0, faultB}, 32'h1);
            end
        end
        checkOutput("bound_no_pc16", {31'b0, saw16}, 32'h0);
        redirectB = 1'b1; targetB = 32'h20;
        @(posedge clk); #1;
        checkOutput("bound_illegal_redirect_fault", {31'b0, faultB}, 32'h1);
        targetB = 32'h4;
        @(posedge clk); #1;
        checkOutput("bound_legal_redirect_fault", {31'b0, faultB}, 32'h0);
        checkOutput("bound_legal_redirect_addr", imemAddrB, 32'h4);
        checkOutput("bound_legal_redirect_valid", {31'b0, validB}, 32'h0);
        redirectB = 1'b0;
        @(posedge clk); #1;
        checkOutput("bound_resume_valid", {31'b0, validB}, 32'h1);
        checkOutput("bound_resume_pc_o", pcOutB, 32'h4);
        checkOutput("bound_resume_inst", instB, memWord(32'h4));

        // Asynchronous reset asserted in the middle of a stall on dut A.
        doReset();
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("stall_pc_o", pcOutA, 32'h8);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", {31'b0, validA}, 32'h0);
        checkOutput("async_inst", instA, NOP);
        checkOutput("async_addr", imemAddrA, 32'h0);
        checkOutput("async_fault", {31'b0, faultA}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_valid", {31'b0, validA}, 32'h1);
        checkOutput("post_reset_pc_o", pcOutA, 32'h0);

        // Randomized traffic on dut A against the reference model.
        doReset();
        mNext = 32'h0; mPc = 32'h0; mInst = NOP; mValid = 1'b0; mFault = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rd  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       tg = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                1:       tg = 32'($urandom_range(0, MEM_A - 1));
                2:       tg = 32'd1008 + 32'($urandom_range(0, 32));
                default: tg = $urandom;
            endcase
            redirectA = rd;
            targetA   = tg;
            readyA    = rdy;
            @(posedge clk);
            modelStep(rd, tg, rdy);
            #1;
            checkOutput($sformatf("rand%0d_valid", c), {31'b0, validA}, {31'b0, mValid});
            checkOutput($sformatf("rand%0d_fault", c), {31'b0, faultA}, {31'b0, mFault});
            checkOutput($sformatf("rand%0d_addr", c), imemAddrA, mNext);
            if (mValid) begin
                checkOutput($sformatf("rand%0d_pc_o", c), pcOutA, mPc);
                checkOutput($sformatf("rand%0d_inst", c), instA, mInst);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; fetch address loaded on reset.
REQ-002 SHALL have parameter MEM_BYTES, default 1024; instruction memory size in bytes, used for fault detection.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port imem_addr  output  32  byte address driven to instruction memory, equal to internal PC.
REQ-006 SHALL have port imem_instr  input  32  instruction word returned combinationally, same cycle, for imem_addr.
REQ-007 SHALL have port redirect_i  input  1  branch/jump taken, flush and reload PC.
REQ-008 SHALL have port redirect_pc_i  input  32  target byte address for redirect.
REQ-009 SHALL have port inst_o  output  32  registered instruction to decoder.
REQ-010 SHALL have port pc_o  output  32  byte address of inst_o.
REQ-011 SHALL have port valid_o  output  1  inst_o/pc_o hold a live instruction.
REQ-012 SHALL have port ready_i  input  1  decoder accepts inst_o this cycle.
REQ-013 SHALL have port fault_o  output  1  sticky fetch fault (out-of-range, or misaligned when enabled).

Function
REQ-014 SHALL keep a 32-bit PC register; imem_addr SHALL equal PC combinationally.
REQ-015 SHALL perform a load when (!valid_o || ready_i) && !redirect_i && !fault_o: inst_o<=imem_instr, pc_o<=PC, valid_o<=1, PC<=PC+4.
REQ-016 SHALL hold inst_o, pc_o, valid_o, PC unchanged while valid_o && !ready_i (stall), with no instruction lost or duplicated.
REQ-017 SHALL clear valid_o to 0 and set PC<=redirect_pc_i on any edge with redirect_i=1, overriding load and stall; first post-redirect instruction SHALL appear valid one cycle later.
REQ-018 SHALL compute PC+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-019 SHALL set fault_o when a load would occur with PC > MEM_BYTES-4; that load SHALL not occur and valid_o SHALL go to 0 once the held instruction is accepted.
REQ-020 SHALL keep fault_o set until reset or a redirect to a legal address, which clears it on that edge.
REQ-021 SHALL sustain one instruction per cycle with ready_i held high (throughput 1, latency 1 cycle PC-to-valid).

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force PC=RESET_PC, valid_o=0, inst_o=32'h0000_0013 (NOP), pc_o=0, fault_o=0.
REQ-023 SHALL, on reset assertion mid-stall or mid-redirect, discard all in-flight state; first valid_o SHALL rise on the first rising edge after rst_n deasserts, with pc_o=RESET_PC.

Configuration
REQ-024 SHALL, with macro FETCH_MISALIGN_TRAP_EN defined, treat redirect_pc_i[1:0]!=0 as a fault: PC takes the target, fault_o=1, no loads until next legal redirect or reset.
REQ-025 SHALL, without FETCH_MISALIGN_TRAP_EN, force redirect_pc_i[1:0] to 2'b00 when loading PC and raise no misalignment fault.

Structure
REQ-026 SHALL take XLEN=32, NOP encoding 32'h0000_0013 and default RESET_PC from shared package fetch_pkg.
REQ-027 SHALL place PC register with next-PC selection (reset/redirect/increment/hold) in sub-module pc_register; output register and handshake stay in instruction_fetch.

Verification
REQ-028 SHALL cover reset release, ready_i=1, memory words 0x00500093,0x00100113 at 0,4 -> cycles 1,2: valid_o=1, pc_o=0 then 4, inst_o matching.
REQ-029 SHALL cover stall: ready_i=0 for 3 cycles at pc_o=8 -> inst_o, pc_o constant, imem_addr=12; ready_i=1 -> next pc_o=12.
REQ-030 SHALL cover redirect during stall: redirect_i=1, redirect_pc_i=0x40 -> next cycle valid_o=0, imem_addr=0x40; following cycle pc_o=0x40, valid_o=1.
REQ-031 SHALL cover bound: MEM_BYTES=16, sequential run -> pc_o 0,4,8,12 delivered, then fault_o=1, valid_o=0, no pc_o=16.
REQ-032 SHALL cover misalign: redirect_pc_i=0x22 -> with FETCH_MISALIGN_TRAP_EN fault_o=1, no valid; without it next pc_o=0x20, fault_o=0.
REQ-033 SHALL cover async reset asserted mid-cycle during stall -> valid_o=0, inst_o=0x00000013, imem_addr=RESET_PC immediately, before next clk edge.
